// File: rtl/rand_engine_arbiter.sv
// Round-robin arbiter sharing one random-number engine among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining RAND_ARB_TIMEOUT_EN.
module rand_engine_arbiter #(
   parameter int NREQ    = 4,
   parameter int NBITS   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_val,
   output logic [NREQ-1:0]  req_rdy,
   output logic [NREQ-1:0]  resp_val,
   input  logic [NREQ-1:0]  resp_rdy,
   output logic [NBITS-1:0] resp_data,
   output logic             eng_go,
   input  logic             eng_done_val,
   input  logic [NBITS-1:0] eng_data,
   output logic             busy
`ifdef RAND_ARB_TIMEOUT_EN
   ,
   output logic             resp_err
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    g_q, g_d;
   logic [NBITS-1:0] data_q, data_d;
   logic [PW-1:0]    win;
   logic [PW-1:0]    win_next;

`ifdef RAND_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`else
   // Without the watchdog the limit has no hardware; keep it visibly consumed.
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   // First requester at or above ptr, searching upward with wrap-around.
   always_comb begin
      logic       found;
      int         idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_val[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      win_next = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
   end

   // NOTE: every combinational output and next-state gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      data_d    = data_q;
      req_rdy   = '0;
      resp_val  = '0;
      resp_data = '0;
      eng_go    = 1'b0;
      busy      = (state_q != IDLE);
`ifdef RAND_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
      resp_err  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req_val) begin
               req_rdy = NREQ'(1) << win;
               g_d     = win;
               ptr_d   = win_next;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            eng_go  = 1'b1;
            state_d = WAIT;
`ifdef RAND_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (eng_done_val) begin
               data_d  = eng_data;
               state_d = RESP;
`ifdef RAND_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef RAND_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         RESP: begin
            resp_val  = NREQ'(1) << g_q;
            resp_data = data_q;
`ifdef RAND_ARB_TIMEOUT_EN
            resp_err  = err_q;
`endif
            if (resp_rdy[g_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         data_q  <= '0;
`ifdef RAND_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         data_q  <= data_d;
`ifdef RAND_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_rand_engine_arbiter.sv
// Directed, table-driven bench for rand_engine_arbiter (NREQ=4, NBITS=32).
module tb_rand_engine_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_val;
   logic [3:0]  req_rdy;
   logic [3:0]  resp_val;
   logic [3:0]  resp_rdy;
   logic [31:0] resp_data;
   logic        eng_go;
   logic        eng_done_val;
   logic [31:0] eng_data;
   logic        busy;
`ifdef RAND_ARB_TIMEOUT_EN
   logic        resp_err;
`endif

   int tests;
   int fails;

   rand_engine_arbiter #(.NREQ(4), .NBITS(32), .TIMEOUT(1024)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_val      (req_val),
      .req_rdy      (req_rdy),
      .resp_val     (resp_val),
      .resp_rdy     (resp_rdy),
      .resp_data    (resp_data),
      .eng_go       (eng_go),
      .eng_done_val (eng_done_val),
      .eng_data     (eng_data),
      .busy         (busy)
`ifdef RAND_ARB_TIMEOUT_EN
      ,
      .resp_err     (resp_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   typedef struct {
      bit          pre_rst;
      logic [3:0]  req;
      int          wait_cycles;
      logic [31:0] data;
      int          bp_cycles;
      logic [1:0]  exp_g;
   } txn_t;

   txn_t tbl [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input logic [1:0] g);
      onehot = 4'b0001 << g;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; req_val = '0; resp_rdy = '0; eng_done_val = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_txn(input txn_t t);
      logic [3:0] oh;
      oh = onehot(t.exp_g);
      if (t.pre_rst) apply_reset();
      @(negedge clk);
      resp_rdy = '0; eng_done_val = 1'b0; req_val = t.req;
      #1;
      check("grant", 64'(req_rdy), 64'(oh));
      check("idle_busy", 64'(busy), 64'(0));
      @(negedge clk);
      #1;
      check("issue_go", 64'(eng_go), 64'(1));
      check("issue_rdy", 64'(req_rdy), 64'(0));
      for (int k = 1; k <= t.wait_cycles; k++) begin
         @(negedge clk);
         if (k == t.wait_cycles) begin
            eng_done_val = 1'b1;
            eng_data     = t.data;
         end
         #1;
         check("wait_go", 64'(eng_go), 64'(0));
         check("wait_resp", 64'(resp_val), 64'(0));
      end
      for (int k = 0; k <= t.bp_cycles; k++) begin
         @(negedge clk);
         eng_done_val = (k % 2) == 1;
         eng_data     = 32'hA5A5_0000 + 32'(k);
         resp_rdy     = (k == t.bp_cycles) ? oh : ~oh;
         #1;
         check("resp_val", 64'(resp_val), 64'(oh));
         check("resp_data", 64'(resp_data), 64'(t.data));
         check("resp_rdy_low", 64'(req_rdy), 64'(0));
         check("resp_go", 64'(eng_go), 64'(0));
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; req_val = '0; resp_rdy = '0; eng_done_val = 1'b0; eng_data = '0;

      tbl[0]  = '{1'b0, 4'b0100, 5, 32'hDEADBEEF, 0,  2'd2};
      tbl[1]  = '{1'b0, 4'b1001, 2, 32'h1111_0001, 1, 2'd3};
      tbl[2]  = '{1'b0, 4'b1001, 1, 32'h2222_0002, 0, 2'd0};
      tbl[3]  = '{1'b1, 4'b1111, 1, 32'h3333_0003, 0, 2'd0};
      tbl[4]  = '{1'b0, 4'b1111, 1, 32'h4444_0004, 0, 2'd1};
      tbl[5]  = '{1'b0, 4'b1111, 2, 32'h5555_0005, 0, 2'd2};
      tbl[6]  = '{1'b0, 4'b1111, 1, 32'h6666_0006, 0, 2'd3};
      tbl[7]  = '{1'b0, 4'b1111, 1, 32'h7777_0007, 0, 2'd0};
      tbl[8]  = '{1'b0, 4'b1111, 3, 32'h8888_0008, 10, 2'd1};
      tbl[9]  = '{1'b0, 4'b0001, 1, 32'h9999_0009, 0, 2'd0};
      tbl[10] = '{1'b0, 4'b0110, 2, 32'hAAAA_000A, 2, 2'd1};

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req_rdy", 64'(req_rdy), 64'(0));
      check("rst_resp_val", 64'(resp_val), 64'(0));
      check("rst_resp_data", 64'(resp_data), 64'(0));
      check("rst_eng_go", 64'(eng_go), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;

      // Idle with no requests: nothing granted, nothing started.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         eng_done_val = (k == 1);
         #1;
         check("idle_rdy", 64'(req_rdy), 64'(0));
         check("idle_go", 64'(eng_go), 64'(0));
         check("idle_busy0", 64'(busy), 64'(0));
      end
      eng_done_val = 1'b0;

      for (int i = 0; i < 11; i++) run_txn(tbl[i]);

      // Reset during WAIT abandons the transaction and clears ptr.
      @(negedge clk);
      resp_rdy = '0; eng_done_val = 1'b0; req_val = 4'b0001;
      #1;
      check("rw_grant", 64'(req_rdy), 64'(4'b0001));
      @(negedge clk);
      req_val = '0;
      #1;
      check("rw_go", 64'(eng_go), 64'(1));
      @(negedge clk);
      #1;
      check("rw_wait_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rw_req_rdy", 64'(req_rdy), 64'(0));
      check("rw_resp_val", 64'(resp_val), 64'(0));
      check("rw_resp_data", 64'(resp_data), 64'(0));
      check("rw_go0", 64'(eng_go), 64'(0));
      check("rw_busy", 64'(busy), 64'(0));
      eng_done_val = 1'b1; eng_data = 32'hCAFE_F00D;
      @(negedge clk);
      eng_done_val = 1'b0;
      #1;
      check("stale_resp_val", 64'(resp_val), 64'(0));
      check("stale_busy", 64'(busy), 64'(0));
      @(negedge clk);
      req_val = 4'b0011;
      #1;
      check("rw_ptr0_grant", 64'(req_rdy), 64'(4'b0001));
      @(negedge clk);
      req_val = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
